// File: rtl/decoder.sv
// N-to-2^N one-hot decoder with a registered shadow copy and sticky per-line coverage.
// Latency: out is combinational; out_q, enable_q and seen lag their inputs by one clk edge.
// Backpressure: none; the block accepts a new select every cycle and never stalls.
module decoder #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N-1:0]      in,
    output logic [(1<<N)-1:0] out,
    output logic [(1<<N)-1:0] out_q,
    output logic              enable_q,
    output logic [(1<<N)-1:0] seen,
    output logic              seen_all
);

    localparam int W = 1 << N;

    // Same-cycle select lines; reset deliberately has no influence here.
    always_comb begin
        out = '0;
        if (enable) begin
            out[in] = 1'b1;
        end
    end

    // A reset edge drops the out value present at that edge, so it never reaches seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            enable_q <= 1'b0;
            seen     <= '0;
        end else begin
            out_q    <= out;
            enable_q <= enable;
            seen     <= seen | out;
        end
    end

    assign seen_all = &seen;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: combinational sweeps at N=1,3,4 and a scoreboarded check of the registered stage.
module tb_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  in;
    logic [7:0]  out, out_q, seen;
    logic        enable_q, seen_all;

    logic        en1, en4;
    logic [0:0]  in1;
    logic [3:0]  in4;
    logic [1:0]  out1, out_q1, seen1;
    logic [15:0] out4, out_q4, seen4;
    logic        enq1, sa1, enq4, sa4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] oq;
        logic       eq;
        logic [7:0] sn;
        logic       sa;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] seen_m;

    always #5 clk = ~clk;

    decoder #(.N(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in(in),
        .out(out), .out_q(out_q), .enable_q(enable_q), .seen(seen), .seen_all(seen_all)
    );

    decoder #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .in(in1),
        .out(out1), .out_q(out_q1), .enable_q(enq1), .seen(seen1), .seen_all(sa1)
    );

    decoder #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .enable(en4), .in(in4),
        .out(out4), .out_q(out_q4), .enable_q(enq4), .seen(seen4), .seen_all(sa4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clocked step: drive at negedge, check out, push expected registers, pop after the edge.
    task automatic step(input logic rst, input logic en, input logic [2:0] idx);
        logic [7:0] eo;
        exp_t       e;
        exp_t       g;
        @(negedge clk);
        reset  = rst;
        enable = en;
        in     = idx;
        eo     = en ? (8'b1 << idx) : 8'h00;
        #1;
        chk("out_live", out, eo);
        if (rst) seen_m = 8'h00;
        else     seen_m = seen_m | eo;
        e.oq = rst ? 8'h00 : eo;
        e.eq = rst ? 1'b0 : en;
        e.sn = seen_m;
        e.sa = &seen_m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            chk("out_q", out_q, g.oq);
            chk("enable_q", enable_q, g.eq);
            chk("seen", seen, g.sn);
            chk("seen_all", seen_all, g.sa);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; in = '0;
        en1 = 1'b0; in1 = '0; en4 = 1'b0; in4 = '0;
        seen_m = 8'h00;

        for (int i = 0; i < 8; i++) begin
            enable = 1'b1; in = i[2:0]; #10;
            chk("dec_en", out, 8'b1 << i);
            chk("dec_en_bit", out[in], 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            enable = 1'b0; in = i[2:0]; #10;
            chk("dec_dis", out, 8'h00);
            chk("dec_dis_bit", out[in], 1'b0);
        end
        enable = 1'b1; in = 3'd5; #10;
        chk("dec_in5", out, 8'h20);

        for (int i = 0; i < 2; i++) begin
            en1 = 1'b1; in1 = i[0:0]; #10;
            chk("n1_en", out1, (i == 0) ? 2'b01 : 2'b10);
            en1 = 1'b0; #10;
            chk("n1_dis", out1, 2'b00);
        end
        for (int i = 0; i < 16; i++) begin
            en4 = 1'b1; in4 = i[3:0]; #10;
            chk("n4_en", out4, 16'h1 << i);
            en4 = 1'b0; #10;
            chk("n4_dis", out4, 16'h0000);
        end
        en4 = 1'b1; in4 = 4'd15; #10;
        chk("n4_in15", out4, 16'h8000);
        en4 = 1'b0;

        // Reset state and registered latency.
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd3);
        chk("lat_out_q", out_q, 8'h08);
        step(1'b0, 1'b0, 3'd0);
        chk("lat_out_q_off", out_q, 8'h00);

        // Sticky coverage, including idle cycles that must not disturb seen.
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd0);
        step(1'b0, 1'b1, 3'd2);
        step(1'b0, 1'b1, 3'd7);
        chk("seen_85", seen, 8'h85);
        chk("seen_all_0", seen_all, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, k[2:0]);
        chk("seen_hold", seen, 8'h85);
        step(1'b0, 1'b1, 3'd1);
        step(1'b0, 1'b1, 3'd3);
        step(1'b0, 1'b1, 3'd4);
        step(1'b0, 1'b1, 3'd5);
        step(1'b0, 1'b1, 3'd6);
        chk("seen_ff", seen, 8'hFF);
        chk("seen_all_1", seen_all, 1'b1);

        // Reset while enabled wins over capture; out keeps decoding.
        step(1'b1, 1'b1, 3'd6);
        step(1'b1, 1'b1, 3'd6);
        chk("rst_out", out, 8'h40);
        chk("rst_seen", seen, 8'h00);
        step(1'b0, 1'b1, 3'd6);
        chk("post_rst_out_q", out_q, 8'h40);
        chk("post_rst_seen", seen, 8'h40);

        // Mid-operation reset discards the value present at the reset edge.
        step(1'b0, 1'b1, 3'd1);
        step(1'b1, 1'b1, 3'd2);
        step(1'b0, 1'b0, 3'd0);
        chk("mid_rst_seen", seen, 8'h00);

        // Randomised tail against the scoreboard model.
        for (int k = 0; k < 40; k++) begin
            step(($urandom_range(0, 9) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
